jpeg_fb_writer: RTL and testbench
=================================

# jpeg_fb_writer

Downstream sink of the JPEG decoder top level. Accepts the decoded pixel stream (X/Y coordinate plus 8-bit R/G/B) under a valid/ready handshake and converts each pixel to RGB565. It computes the framebuffer byte address, merges horizontally adjacent pixels into 32-bit little-endian words with byte strobes, and issues them on a single-outstanding write-request port to the memory/bus adapter.

## Interface
- `FLUSH_CYCLES`, 16: idle cycles after which a half-filled pending word is written out (range 1..255).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_base`  in  32  framebuffer byte base address; bit 1:0 zero; sampled per pixel.
- `cfg_stride`  in  16  line pitch in bytes; even; sampled per pixel.
- `frame_start`  in  1  one-cycle pulse; discards the pending word and the S1 stage.
- `flush`  in  1  one-cycle pulse; forces the pending word out at the next free output slot.
- `in_valid`  in  1  pixel valid (decoder OutEnable).
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready` (drives decoder OutReady).
- `in_x`, `in_y`  in  16 each  pixel coordinate.
- `in_r`, `in_g`, `in_b`  in  8 each  pixel colour.
- `wr_req`  out  1  write request.
- `wr_addr`  out  32  word address; bits 1:0 always 0.
- `wr_data`  out  32  data; pixel at byte offset 0 in [15:0], offset 2 in [31:16].
- `wr_strb`  out  4  byte enables: 0011, 1100, or 1111.
- `wr_accept`  in  1  the write completes on a cycle where `wr_req && wr_accept`.
- `busy`  out  1  S1 valid, a word pending, or `wr_req` high.

## Operation
- RGB565 = {r[7:3], g[7:2], b[7:3]}; truncate, no rounding.
- S1 (address stage) registers `addr = cfg_base + in_y*cfg_stride + {in_x,1'b0}`. The product is 32 bits and the sum wraps modulo 2^32. S1 also registers the 565 value.
- S2 (pack) holds at most one pending word: `pend_valid`, `pend_waddr` (addr[31:2]), `pend_data`, `pend_strb`, plus an 8-bit age counter.
- S1 → S2 actions:
  - No pending word: load the pixel into the half selected by addr[1] and set the matching strobe.
  - Pending word, same word address: merge the pixel into its half. Strobe becomes 1111 → emit immediately and clear pending.
  - Pending word, different word address: emit the old word and load the new pixel as pending.
  - Same word and same half (duplicate coordinate): the later pixel overwrites; the strobe is unchanged.
- "Emit" loads the output register (`wr_req`=1, addr/data/strb). It is permitted only when the output register is empty (`wr_req`=0) at the start of the cycle. Otherwise S1 stalls.
- `in_ready = !s1_valid || s1_advance`, where `s1_advance = !needs_emit || !wr_req`. It depends on registered state only; there is no combinational path from `wr_accept`.
- The age counter resets on every S2 load or merge and increments while pending with no S1 arrival. At `FLUSH_CYCLES`, or on `flush`, the pending word is emitted when the output register is free. If an emit from S1 is also needed that cycle, the S1 emit wins; the timeout and `flush` are dropped because the pending word is being emitted anyway.
- `frame_start` clears S1 valid, `pend_valid`, and the age counter. It does not cancel an issued `wr_req`.
- Output register: `wr_req` rises on emit and holds addr/data/strb stable until `wr_accept`. It clears the cycle after acceptance. There is no back-to-back emit in the acceptance cycle.

## Timing
- Reset values: `wr_req`=0, `wr_addr`=0, `wr_data`=0, `wr_strb`=0, `busy`=0, `in_ready`=1. All internal valids and counters are 0.
- Latency, pixel completing a word: accepted at cycle t → S1 at t+1 → `wr_req` at t+2.
- Latency, lone pixel: `wr_req` appears FLUSH_CYCLES+2 cycles after acceptance, absent further input.
- Throughput is 1 pixel/cycle when words fill with `wr_accept` tied high. A word emit blocks the next emit for one cycle.
- Reset asserted mid-transfer: all state is lost immediately and any in-flight `wr_req` is dropped.

## Structure
- Shared package `jpeg_fb_pkg`:
  - RGB565 pack function.
  - Strobe constants STRB_LO=4'b0011, STRB_HI=4'b1100, STRB_ALL=4'b1111.
  - Default FLUSH_CYCLES.
- Sub-module `jpeg_fb_addr_gen`: the registered multiply-add address stage (S1).
- Pack, age counter, and output register stay in the top module.

## Test plan
- Pair merge: base 0x1000_0000, stride 0x0500. Pixels (0,0) FF/00/00 then (1,0) 00/FF/00 back-to-back, `wr_accept`=1. Expect one write: addr 0x1000_0000, data 0x07E0_F800, strb 1111, `wr_req` 2 cycles after the second pixel.
- Non-adjacent: pixel (3,1) B=FF, then (8,1). Expect write addr 0x1000_0504, data 0x001F_0000, strb 1100 when (8,1) reaches S2. (8,1) stays pending.
- Timeout: single pixel (2,0) R=FF, FLUSH_CYCLES=16. Expect addr 0x1000_0004, data 0x0000_F800, strb 0011, exactly 18 cycles after acceptance.
- Backpressure: hold `wr_accept`=0 for 20 cycles while streaming 8 pixels. Expect `in_ready` to drop; no pixel lost or duplicated. All 4 full words are written in order after release, and each payload is stable while `wr_req` is held.
- `frame_start` with a half word pending: no write is issued and `busy` drops next cycle. Then (0,0)+(1,0) produce one clean full write.
- Async reset mid-burst with `wr_req`=1: outputs are at reset values immediately, `in_ready`=1, and no write occurs after release.

Source files
------------

// File: rtl/jpeg_fb_pkg.sv
// Shared definitions for the JPEG framebuffer writer: strobe patterns,
// default flush timeout and the RGB888 -> RGB565 packing helper.
package jpeg_fb_pkg;

  localparam int FLUSH_CYCLES_DEF = 16;

  localparam logic [3:0] STRB_LO  = 4'b0011;
  localparam logic [3:0] STRB_HI  = 4'b1100;
  localparam logic [3:0] STRB_ALL = 4'b1111;

  // Truncating RGB565 pack: top 5/6/5 bits of each channel, no rounding.
  function automatic logic [15:0] packRgb565(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/jpeg_fb_addr_gen.sv
// Address stage: registers the framebuffer byte address of an accepted
// pixel (base + y*stride + 2*x, modulo 2^32) together with its RGB565 value.
module jpeg_fb_addr_gen
  import jpeg_fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frameStart,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] base,
  input  logic [15:0] stride,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        vld_p1,
  output logic [31:0] addr_p1,
  output logic [15:0] pix_p1
);

  logic [31:0] rowOffset;
  logic [31:0] byteAddr;

  assign rowOffset = {16'd0, y} * {16'd0, stride};
  assign byteAddr  = base + rowOffset + {15'd0, x, 1'b0};

  // ---- S1 boundary: valid tracks accepted pixels; a fresh pixel beats a discard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (frameStart || advance) begin
      vld_p1 <= 1'b0;
    end
  end

  // S1 payload captured on acceptance; no reset needed, qualified by vld_p1
  always_ff @(posedge clk) begin
    if (load) begin
      addr_p1 <= byteAddr;
      pix_p1  <= packRgb565(r, g, b);
    end
  end

endmodule

// File: rtl/jpeg_fb_writer.sv
// JPEG framebuffer writer: accepts decoded pixels, converts to RGB565,
// packs horizontally adjacent pixels into 32-bit words and issues them on a
// single-outstanding write port. A lone half word is written after an idle
// timeout or on flush.
module jpeg_fb_writer
  import jpeg_fb_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_base,
  input  logic [15:0] cfg_stride,
  input  logic        frame_start,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic        wr_accept,
  output logic        busy
);

  localparam logic [7:0] AGE_LIMIT = 8'(FLUSH_CYCLES - 1);

  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [15:0] pix_p1;

  logic        pendValid_p2;
  logic [29:0] pendWaddr_p2;
  logic [31:0] pendData_p2;
  logic [3:0]  pendStrb_p2;
  logic [7:0]  age_p2;
  logic        flushReq_p2;

  logic        pendValidNxt;
  logic [29:0] pendWaddrNxt;
  logic [31:0] pendDataNxt;
  logic [3:0]  pendStrbNxt;
  logic [7:0]  ageNxt;
  logic        flushReqNxt;

  logic        emit;
  logic [29:0] emitWaddr;
  logic [31:0] emitData;
  logic [3:0]  emitStrb;

  logic        accept;
  logic        sameWord;
  logic [3:0]  newStrb;
  logic [3:0]  mergedStrb;
  logic [31:0] mergedData;
  logic [31:0] loadData;
  logic        needsEmit;
  logic        s1Advance;
  logic        s1Fire;
  logic        timeoutHit;
  logic        idleEmit;
  logic        unusedAddrBit;

  // Byte address bit 0 is always zero (even stride, aligned base, 2*x).
  assign unusedAddrBit = addr_p1[0];

  assign newStrb    = addr_p1[1] ? STRB_HI : STRB_LO;
  assign sameWord   = pendValid_p2 && (pendWaddr_p2 == addr_p1[31:2]);
  assign mergedStrb = pendStrb_p2 | newStrb;
  assign mergedData = addr_p1[1] ? {pix_p1, pendData_p2[15:0]}
                                 : {pendData_p2[31:16], pix_p1};
  assign loadData   = addr_p1[1] ? {pix_p1, 16'h0000} : {16'h0000, pix_p1};

  // S1 can only move on if its action needs no emit, or the output slot is free.
  assign needsEmit  = vld_p1 && pendValid_p2 && (!sameWord || (mergedStrb == STRB_ALL));
  assign s1Advance  = !needsEmit || !wr_req;
  assign in_ready   = !vld_p1 || s1Advance;
  assign accept     = in_valid && in_ready;
  assign s1Fire     = vld_p1 && s1Advance && !frame_start;

  assign timeoutHit = (age_p2 >= AGE_LIMIT);
  assign idleEmit   = pendValid_p2 && !wr_req && (timeoutHit || flushReq_p2 || flush);

  assign busy       = vld_p1 || pendValid_p2 || wr_req;

  // ---- S1: address stage
  jpeg_fb_addr_gen uAddrGen (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frame_start),
    .load       (accept),
    .advance    (s1Advance),
    .base       (cfg_base),
    .stride     (cfg_stride),
    .x          (in_x),
    .y          (in_y),
    .r          (in_r),
    .g          (in_g),
    .b          (in_b),
    .vld_p1     (vld_p1),
    .addr_p1    (addr_p1),
    .pix_p1     (pix_p1)
  );

  // ---- S2: pack decision; S1 emits take priority over timeout/flush emits
  always_comb begin
    pendValidNxt = pendValid_p2;
    pendWaddrNxt = pendWaddr_p2;
    pendDataNxt  = pendData_p2;
    pendStrbNxt  = pendStrb_p2;
    ageNxt       = age_p2;
    flushReqNxt  = flushReq_p2 | flush;
    emit         = 1'b0;
    emitWaddr    = pendWaddr_p2;
    emitData     = pendData_p2;
    emitStrb     = pendStrb_p2;
    if (frame_start) begin
      pendValidNxt = 1'b0;
      ageNxt       = '0;
      flushReqNxt  = 1'b0;
    end else if (s1Fire) begin
      ageNxt = '0;
      if (sameWord) begin
        pendDataNxt = mergedData;
        pendStrbNxt = mergedStrb;
        if (mergedStrb == STRB_ALL) begin
          emit         = 1'b1;
          emitData     = mergedData;
          emitStrb     = STRB_ALL;
          pendValidNxt = 1'b0;
          flushReqNxt  = 1'b0;
        end
      end else begin
        emit = pendValid_p2;
        if (pendValid_p2) begin
          flushReqNxt = 1'b0;
        end
        pendValidNxt = 1'b1;
        pendWaddrNxt = addr_p1[31:2];
        pendDataNxt  = loadData;
        pendStrbNxt  = newStrb;
      end
    end else if (idleEmit) begin
      emit         = 1'b1;
      pendValidNxt = 1'b0;
      ageNxt       = '0;
      flushReqNxt  = 1'b0;
    end else if (pendValid_p2) begin
      if (age_p2 != 8'hFF) begin
        ageNxt = age_p2 + 8'd1;
      end
    end else begin
      flushReqNxt = 1'b0;
    end
  end

  // S2 control state: pending valid, idle age and latched flush request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pendValid_p2 <= 1'b0;
      age_p2       <= '0;
      flushReq_p2  <= 1'b0;
    end else begin
      pendValid_p2 <= pendValidNxt;
      age_p2       <= ageNxt;
      flushReq_p2  <= flushReqNxt;
    end
  end

  // S2 pending word payload, qualified by pendValid_p2
  always_ff @(posedge clk) begin
    pendWaddr_p2 <= pendWaddrNxt;
    pendData_p2  <= pendDataNxt;
    pendStrb_p2  <= pendStrbNxt;
  end

  // ---- Output register: holds the request stable until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else if (emit) begin
      wr_req  <= 1'b1;
      wr_addr <= {emitWaddr, 2'b00};
      wr_data <= emitData;
      wr_strb <= emitStrb;
    end else if (wr_req && wr_accept) begin
      wr_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// Directed + randomized bench for jpeg_fb_writer with a word-level reference model.
module tb_jpeg_fb_writer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_base;
  logic [15:0] cfg_stride;
  logic        frame_start;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_accept = 1'b0;
  logic        busy;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  unstable = 0;
  bit  sawStall = 0;
  bit  acceptLevel = 1;
  bit  randomAccept = 0;
  bit  prevHold = 0;
  wr_t prevW;

  wr_t         wrQ[$];
  wr_t         expQ[$];
  logic [31:0] pxA[$];
  logic [15:0] pxV[$];

  jpeg_fb_writer #(.FLUSH_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .frame_start (frame_start),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_accept   (wr_accept),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port acceptance driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_accept = randomAccept ? 1'($urandom_range(0, 1)) : acceptLevel;
    end
  end

  // Monitor: completed writes, payload stability while held, input stalls
  always @(negedge clk) begin
    if (rst && wr_req && wr_accept) wrQ.push_back({wr_addr, wr_data, wr_strb});
    if (rst && prevHold && wr_req && ({wr_addr, wr_data, wr_strb} != prevW)) unstable++;
    prevHold = rst && wr_req && !wr_accept;
    prevW    = {wr_addr, wr_data, wr_strb};
    if (rst && in_valid && !in_ready) sawStall = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel until accepted; returns the acceptance cycle
  task automatic sendPx(input int x, input int y, input int r, input int g, input int b,
                        output int acc);
    in_x = 16'(x); in_y = 16'(y);
    in_r = 8'(r);  in_g = 8'(g);  in_b = 8'(b);
    in_valid = 1'b1;
    acc = -1;
    pxA.push_back(cfg_base + 32'(y) * 32'(cfg_stride) + 32'(x) * 32'd2);
    pxV.push_back(rgb(r, g, b));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitReq(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (wr_req) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic waitIdle(input string tag, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
    align();
  endtask

  // Reference: walk the pixel list, grouping by 32-bit word as the stream arrives
  task automatic buildExpected();
    bit          pv;
    logic [29:0] pw;
    logic [31:0] pd;
    logic [3:0]  ps;
    expQ.delete();
    pv = 0; pw = '0; pd = '0; ps = '0;
    foreach (pxA[i]) begin
      logic [29:0] w;
      logic [31:0] lane;
      logic [31:0] keep;
      logic [3:0]  ls;
      w    = pxA[i] / 4;
      lane = pxA[i][1] ? {pxV[i], 16'h0000} : {16'h0000, pxV[i]};
      keep = pxA[i][1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      ls   = pxA[i][1] ? 4'b1100 : 4'b0011;
      if (pv && w == pw) begin
        pd = (pd & keep) | lane;
        ps = ps | ls;
        if (ps == 4'hF) begin
          expQ.push_back({pw, 2'b00, pd, ps});
          pv = 0;
        end
      end else begin
        if (pv) expQ.push_back({pw, 2'b00, pd, ps});
        pv = 1; pw = w; pd = lane; ps = ls;
      end
    end
    if (pv) expQ.push_back({pw, 2'b00, pd, ps});
  endtask

  task automatic compareWrites(input string tag);
    check({tag, "_count"}, 32'(wrQ.size()), 32'(expQ.size()));
    foreach (expQ[i]) begin
      if (i < wrQ.size()) begin
        check({tag, "_addr"}, wrQ[i].a, expQ[i].a);
        check({tag, "_data"}, wrQ[i].d, expQ[i].d);
        check({tag, "_strb"}, 32'(wrQ[i].s), 32'(expQ[i].s));
      end
    end
  endtask

  initial begin
    int a1, a2, t;
    int x, y, sel;
    rst = 1'b0;
    cfg_base = 32'h1000_0000; cfg_stride = 16'h0500;
    frame_start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_x = '0; in_y = '0; in_r = '0; in_g = '0; in_b = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_wr_strb", 32'(wr_strb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    align();
    rst = 1'b1;
    align();

    // Pair merge
    wrQ.delete(); pxA.delete(); pxV.delete();
    sendPx(0, 0, 8'hFF, 8'h00, 8'h00, a1);
    sendPx(1, 0, 8'h00, 8'hFF, 8'h00, a2);
    waitReq(20, t);
    check("pair_latency", 32'(t), 32'(a2 + 2));
    check("pair_addr", wr_addr, 32'h1000_0000);
    check("pair_data", wr_data, 32'h07E0_F800);
    check("pair_strb", 32'(wr_strb), 32'hF);
    waitIdle("pair_idle", 10);
    check("pair_count", 32'(wrQ.size()), 32'd1);

    // Non-adjacent pixels, then flush the remaining half word
    wrQ.delete(); pxA.delete(); pxV.delete();
    sendPx(3, 1, 8'h00, 8'h00, 8'hFF, a1);
    sendPx(8, 1, 8'h10, 8'h20, 8'h30, a2);
    waitReq(20, t);
    check("nadj_latency", 32'(t), 32'(a2 + 2));
    check("nadj_addr", wr_addr, 32'h1000_0504);
    check("nadj_data", wr_data, 32'h001F_0000);
    check("nadj_strb", 32'(wr_strb), 32'hC);
    align();
    flush = 1'b1;
    align();
    flush = 1'b0;
    waitIdle("flush_idle", 6);
    check("flush_count", 32'(wrQ.size()), 32'd2);
    if (wrQ.size() == 2) begin
      check("flush_addr", wrQ[1].a, 32'h1000_0510);
      check("flush_data", wrQ[1].d, 32'h0000_1106);
      check("flush_strb", 32'(wrQ[1].s), 32'h3);
    end

    // Timeout of a lone pixel
    wrQ.delete(); pxA.delete(); pxV.delete();
    sendPx(2, 0, 8'hFF, 8'h00, 8'h00, a1);
    waitReq(40, t);
    check("tmo_latency", 32'(t), 32'(a1 + 18));
    check("tmo_addr", wr_addr, 32'h1000_0004);
    check("tmo_data", wr_data, 32'h0000_F800);
    check("tmo_strb", 32'(wr_strb), 32'h3);
    waitIdle("tmo_idle", 10);

    // Backpressure: write port blocked for 20 cycles while streaming 8 pixels
    wrQ.delete(); pxA.delete(); pxV.delete();
    acceptLevel = 0; sawStall = 0; unstable = 0;
    align();
    fork
      begin
        int acc;
        for (int i = 0; i < 8; i++)
          sendPx(i, 2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), acc);
      end
      begin
        repeat (20) @(posedge clk);
        acceptLevel = 1;
      end
    join
    waitIdle("bp_idle", 100);
    buildExpected();
    check("bp_expected_words", 32'(expQ.size()), 32'd4);
    compareWrites("bp");
    check("bp_stalled", 32'(sawStall), 32'd1);
    check("bp_stable", 32'(unstable), 32'd0);

    // frame_start discards a pending half word
    wrQ.delete(); pxA.delete(); pxV.delete();
    sendPx(0, 3, 8'h55, 8'h66, 8'h77, a1);
    align();
    align();
    frame_start = 1'b1;
    align();
    frame_start = 1'b0;
    @(negedge clk);
    check("fs_busy", 32'(busy), 32'd0);
    repeat (30) align();
    check("fs_no_write", 32'(wrQ.size()), 32'd0);
    pxA.delete(); pxV.delete();
    sendPx(0, 0, 8'h12, 8'h34, 8'h56, a1);
    sendPx(1, 0, 8'h9A, 8'hBC, 8'hDE, a2);
    waitIdle("fs_idle", 10);
    buildExpected();
    compareWrites("fs");

    // Randomized stream with random write acceptance
    wrQ.delete(); pxA.delete(); pxV.delete();
    cfg_base   = $urandom & 32'hFFFF_FFFC;
    cfg_stride = 16'($urandom_range(8, 4000) * 2);
    randomAccept = 1; unstable = 0;
    x = 0; y = 0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) x = (x + 1) % 100;
      else if (sel < 8) begin
        x = $urandom_range(0, 20);
        y = $urandom_range(0, 5);
      end
      sendPx(x, y, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), a1);
      repeat ($urandom_range(0, 2)) align();
    end
    waitIdle("rnd_idle", 400);
    randomAccept = 0;
    buildExpected();
    compareWrites("rnd");
    check("rnd_stable", 32'(unstable), 32'd0);

    // Asynchronous reset while a write is outstanding
    cfg_base = 32'h1000_0000; cfg_stride = 16'h0500;
    acceptLevel = 0;
    align();
    wrQ.delete(); pxA.delete(); pxV.delete();
    sendPx(0, 0, 8'hAA, 8'hBB, 8'hCC, a1);
    sendPx(1, 0, 8'h11, 8'h22, 8'h33, a2);
    waitReq(20, t);
    check("ar_req_before", 32'(wr_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_wr_req", 32'(wr_req), 32'd0);
    check("ar_wr_addr", wr_addr, 32'd0);
    check("ar_wr_data", wr_data, 32'd0);
    check("ar_wr_strb", 32'(wr_strb), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_busy", 32'(busy), 32'd0);
    align();
    rst = 1'b1;
    acceptLevel = 1;
    repeat (30) align();
    check("ar_no_write", 32'(wrQ.size()), 32'd0);
    check("ar_req_after", 32'(wr_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
